// File: rtl/keypad_press_ctrl_if.sv
// Scanner-to-display signal bundle for keypad_press_ctrl.
// The master side drives the scanner inputs; the slave side is the controller.
interface keypad_press_ctrl_if;
    logic       key_onebit;
    logic [4:0] keypad_val;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;
    logic       key_held;
    logic [7:0] press_count;

    modport master (
        output key_onebit, keypad_val,
        input  digit_new, digit_old, key_valid, key_held, press_count
    );

    modport slave (
        input  key_onebit, keypad_val,
        output digit_new, digit_old, key_valid, key_held, press_count
    );
endinterface

// File: rtl/keypad_press_ctrl.sv
// Debounces keypad scanner presses, commits one event per physical press and
// keeps a two-digit history, a press counter and a key-held flag.
module keypad_press_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    keypad_press_ctrl_if.slave kp
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;
    logic [3:0]       digit_new;
    logic [3:0]       digit_old;
    logic             key_valid;
    logic             key_held;
    logic [7:0]       press_count;
    logic             pressed;

    assign pressed = kp.key_onebit & ~kp.keypad_val[4];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cand        <= '0;
            digit_new   <= '0;
            digit_old   <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            press_count <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pressed) begin
                        cand  <= kp.keypad_val[3:0];
                        cnt   <= CNT_ONE;
                        state <= S_PRESS_WAIT;
                    end else begin
                        cnt <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    // A release or value change on the final sample still aborts the commit.
                    if (!pressed || (kp.keypad_val[3:0] != cand)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        digit_old   <= digit_new;
                        digit_new   <= cand;
                        press_count <= press_count + 8'd1;
                        key_valid   <= 1'b1;
                        key_held    <= 1'b1;
                        state       <= S_HELD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!pressed) begin
                        cnt   <= CNT_ONE;
                        state <= S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (pressed) begin
                        cnt   <= '0;
                        state <= S_HELD;
                    end else if (cnt == CNT_LAST) begin
                        key_held <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign kp.digit_new   = digit_new;
    assign kp.digit_old   = digit_old;
    assign kp.key_valid   = key_valid;
    assign kp.key_held    = key_held;
    assign kp.press_count = press_count;

endmodule

// File: tb/tb_keypad_press_ctrl.sv
// Directed bench for keypad_press_ctrl with DEBOUNCE_CYCLES=4; committed
// events are predicted into a scoreboard queue and matched on each key_valid.
module tb_keypad_press_ctrl;

    typedef struct packed {
        logic [3:0] nw;
        logic [3:0] old;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    logic kv_prev  = 1'b0;

    exp_t       sb[$];
    logic [3:0] m_new = '0;
    logic [3:0] m_old = '0;
    logic [7:0] m_cnt = '0;

    keypad_press_ctrl_if kp();

    keypad_press_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every key_valid pulse must match the oldest predicted commit.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            exp_t e;
            pulses++;
            check("valid_not_back_to_back", {31'd0, kv_prev}, 32'd0);
            check("unexpected_pulse", {31'd0, sb.size() == 0}, 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_digit_new", {28'd0, kp.digit_new}, {28'd0, e.nw});
                check("sb_digit_old", {28'd0, kp.digit_old}, {28'd0, e.old});
                check("sb_press_count", {24'd0, kp.press_count}, {24'd0, e.cnt});
                check("sb_key_held", {31'd0, kp.key_held}, 32'd1);
            end
        end
        kv_prev = kp.key_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic onebit, input logic [4:0] val);
        kp.key_onebit = onebit;
        kp.keypad_val = val;
    endtask

    task automatic expect_commit(input logic [3:0] k);
        exp_t e;
        e.nw  = k;
        e.old = m_new;
        e.cnt = m_cnt + 8'd1;
        sb.push_back(e);
        m_old = m_new;
        m_new = k;
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic model_reset();
        m_new = '0;
        m_old = '0;
        m_cnt = '0;
        sb.delete();
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        drive(1'b1, {1'b0, k});
        if (hold >= 4) expect_commit(k);
        cyc(hold);
        drive(1'b0, 5'd31);
        cyc(rel);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_digit_new"}, {28'd0, kp.digit_new}, {28'd0, m_new});
        check({tag, "_digit_old"}, {28'd0, kp.digit_old}, {28'd0, m_old});
        check({tag, "_press_count"}, {24'd0, kp.press_count}, {24'd0, m_cnt});
        check({tag, "_key_valid"}, {31'd0, kp.key_valid}, 32'd0);
    endtask

    initial begin
        int p0;

        // Reset held with a key already pressed.
        reset = 1'b0;
        drive(1'b1, 5'd7);
        cyc(2);
        model_reset();
        check_outputs("reset");
        check("reset_key_held", {31'd0, kp.key_held}, 32'd0);
        reset = 1'b1;
        expect_commit(4'd7);
        cyc(3);
        check("reset_no_early_valid", {31'd0, kp.key_valid}, 32'd0);
        cyc(1);
        check("reset_valid_4th", {31'd0, kp.key_valid}, 32'd1);
        check("reset_commit_digit", {28'd0, kp.digit_new}, 32'd7);
        check("reset_commit_count", {24'd0, kp.press_count}, 32'd1);
        cyc(2);

        // Reset mid-operation while held clears history.
        drive(1'b0, 5'd31);
        reset = 1'b0;
        cyc(1);
        model_reset();
        reset = 1'b1;
        check_outputs("midreset");
        check("midreset_key_held", {31'd0, kp.key_held}, 32'd0);
        cyc(2);

        // Clean press of key 5: 10 held, 10 released.
        p0 = pulses;
        drive(1'b1, 5'd5);
        expect_commit(4'd5);
        cyc(3);
        check("clean_no_early_valid", {31'd0, kp.key_valid}, 32'd0);
        cyc(1);
        check("clean_valid", {31'd0, kp.key_valid}, 32'd1);
        cyc(1);
        check("clean_valid_one_cycle", {31'd0, kp.key_valid}, 32'd0);
        cyc(5);
        drive(1'b0, 5'd31);
        cyc(3);
        check("clean_held_before_release", {31'd0, kp.key_held}, 32'd1);
        cyc(1);
        check("clean_held_released", {31'd0, kp.key_held}, 32'd0);
        cyc(6);
        check_outputs("clean");
        check("clean_pulses", pulses - p0, 32'd1);

        // Bounce on key 9, final low coincides with the would-be commit edge.
        p0 = pulses;
        drive(1'b1, 5'd9); cyc(2);
        drive(1'b0, 5'd31); cyc(1);
        drive(1'b1, 5'd9); cyc(3);
        drive(1'b0, 5'd31); cyc(6);
        check_outputs("bounce");
        check("bounce_pulses", pulses - p0, 32'd0);
        check("bounce_key_held", {31'd0, kp.key_held}, 32'd0);

        // Flag high but value 31 is not a press.
        p0 = pulses;
        drive(1'b1, 5'd31); cyc(6);
        drive(1'b0, 5'd31); cyc(2);
        check("none_value_pulses", pulses - p0, 32'd0);

        // Value change 3 -> A mid-debounce restarts via IDLE.
        p0 = pulses;
        drive(1'b1, 5'd3); cyc(2);
        drive(1'b1, 5'd10);
        expect_commit(4'hA);
        cyc(4);
        check("change_no_early_valid", {31'd0, kp.key_valid}, 32'd0);
        cyc(1);
        check("change_valid", {31'd0, kp.key_valid}, 32'd1);
        cyc(3);
        drive(1'b0, 5'd31); cyc(6);
        check_outputs("change");
        check("change_pulses", pulses - p0, 32'd1);

        // History, then release bounce on C.
        press(4'd1, 6, 6);
        check_outputs("hist1");
        p0 = pulses;
        drive(1'b1, 5'd12);
        expect_commit(4'hC);
        cyc(6);
        drive(1'b0, 5'd31); cyc(1);
        check("glitch_held_1", {31'd0, kp.key_held}, 32'd1);
        cyc(1);
        check("glitch_held_2", {31'd0, kp.key_held}, 32'd1);
        drive(1'b1, 5'd12); cyc(4);
        check("glitch_held_after", {31'd0, kp.key_held}, 32'd1);
        drive(1'b0, 5'd31); cyc(6);
        check("glitch_released", {31'd0, kp.key_held}, 32'd0);
        check_outputs("hist2");
        check("hist_old_is_1", {28'd0, kp.digit_old}, 32'd1);
        check("glitch_pulses", pulses - p0, 32'd1);

        // Counter wrap over 256 clean presses from zero.
        reset = 1'b0;
        cyc(1);
        model_reset();
        reset = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 255; i++) press(i[3:0], 5, 5);
        check("wrap_count_255", {24'd0, kp.press_count}, 32'd255);
        press(4'd6, 5, 5);
        check("wrap_count_0", {24'd0, kp.press_count}, 32'd0);
        check("wrap_pulses", pulses - p0, 32'd256);
        check_outputs("wrap");
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_press_ctrl.md
# keypad_press_ctrl

Sequencing controller between the 4x4 keypad scanner and the dual seven-segment display path. Debounces the scanner's raw "key pressed" flag and value, commits exactly one event per physical press, and shifts committed digits into a two-digit history (newest/previous) for display. Also counts committed presses and flags key-held status. A held key, bounce, or a value change mid-debounce never produces a second event.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable samples required to accept a press or a release. Legal range is 2 to 2^20.
- CNT_W, default $clog2(DEBOUNCE_CYCLES): debounce counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- key_onebit  in  1  scanner flag; high while the scanner reports a pressed key.
- keypad_val  in  5  scanner value; 0–15 is key 0–F, 31 is none.
- digit_new  out  4  most recently committed key.
- digit_old  out  4  key committed before digit_new.
- key_valid  out  1  one-cycle pulse, coincident with the digit update.
- key_held  out  1  high from commit until the release is debounced.
- press_count  out  8  committed presses, modulo 256.

## Operation
- Definitions:
  - pressed = key_onebit & ~keypad_val[4].
  - cand is a 4-bit register holding the value under debounce.
  - cnt is a CNT_W-bit counter.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - If pressed: cand <= keypad_val[3:0], cnt <= 1, go to PRESS_WAIT.
  - Else stay, with cnt <= 0.
- PRESS_WAIT:
  - If !pressed or keypad_val[3:0] != cand: go to IDLE, cnt <= 0, no event.
  - Else if cnt == DEBOUNCE_CYCLES-1: commit and go to HELD.
  - Else cnt <= cnt+1.
- Commit, all in one edge:
  - digit_old <= digit_new.
  - digit_new <= cand.
  - press_count <= press_count+1 (wraps 255 to 0).
  - key_valid <= 1.
  - key_held <= 1.
- HELD:
  - If !pressed: cnt <= 1, go to RELEASE_WAIT.
  - Else stay. Value changes are ignored.
- RELEASE_WAIT:
  - If pressed: go to HELD, cnt <= 0. Bounce is absorbed and no new event is produced.
  - Else if cnt == DEBOUNCE_CYCLES-1: go to IDLE, key_held <= 0.
  - Else cnt <= cnt+1.
- key_valid is registered and cleared on every edge other than a commit edge. It is never high two cycles in a row.
- Illegal or unreachable state encodings go to IDLE on the next edge, with outputs unchanged except key_valid <= 0.

## Timing
- Reset values: state=IDLE, cnt=0, cand=0, digit_new=0, digit_old=0, key_valid=0, key_held=0, press_count=0.
- Press latency: pressed is first sampled high at edge E0 (in IDLE). If stable, commit occurs at edge E0+DEBOUNCE_CYCLES-1. key_valid and the new digits are visible in the cycle following that edge. This totals DEBOUNCE_CYCLES consecutive stable samples.
- Release latency: pressed is first sampled low at edge R0 (in HELD). If low stays continuous, key_held falls after edge R0+DEBOUNCE_CYCLES-1.
- Earliest next commit after a release returns to IDLE: DEBOUNCE_CYCLES edges after the next pressed sample.
- Reset mid-operation: all registers take reset values on that edge, and history is lost. A key still physically held after reset deasserts is re-debounced from IDLE and committed as a new event. This is required behaviour.
- Simultaneous release and commit edge: the commit does not happen, because pressed low in PRESS_WAIT takes priority.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold reset=0 for 2 cycles with pressed asserted, then release reset. All outputs are 0 at release. The press then commits 4 samples later, with digit_new=that key and press_count=1.
- Clean press: key 5 (key_onebit=1, keypad_val=5) held 10 cycles, then released 10 cycles. Response:
  - Exactly one key_valid pulse, on the cycle after the 4th stable sample.
  - digit_new=5, digit_old=0, press_count=1.
  - key_held falls 4 cycles after release.
- Bounce: key 9 toggled high 2 cycles, low 1, high 3, low. Response: no key_valid, digits unchanged, state back to IDLE.
- Value change in debounce: keypad_val 3 for 2 samples, then A with key_onebit held. Response: restart via IDLE, then commit digit_new=A after 4 stable A samples. No event for 3.
- History and release bounce:
  - Press 1 and release, then press C. Expect digit_old=1, digit_new=C.
  - During the C release, a 2-cycle low glitch followed by pressed again gives no second pulse, and key_held stays 1.
- Counter wrap: 256 clean presses give press_count=0 after the last commit. Exactly 256 key_valid pulses are counted.
